// File: rtl/line_timing_gen.sv
// line_timing_gen: line/frame timing FSM producing sync, end-of-line and end-of-frame strobes
// plus pixel, line and frame position counters, all registered.
module line_timing_gen #(
   parameter int PIX_PER_LINE    = 1290,
   parameter int LINES_PER_FRAME = 16,
   parameter int HBLANK          = 8,
   parameter int VBLANK          = 32,
   parameter int PW              = 12,
   parameter int LW              = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic          f_sync,
   output logic          sync,
   output logic          endLine,
   output logic          endFrame,
   output logic [PW-1:0] pix_cnt,
   output logic [LW-1:0] line_cnt,
   output logic [7:0]    frame_cnt,
   output logic          busy
);
   localparam int BMAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
   localparam int BW   = $clog2(BMAX + 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(PIX_PER_LINE - 1);
   localparam logic [LW-1:0] LINE_LAST = LW'(LINES_PER_FRAME - 1);
   localparam logic [BW-1:0] HB_LAST   = BW'(HBLANK - 1);
   localparam logic [BW-1:0] VB_LAST   = BW'(VBLANK - 1);

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

   state_t          st_q, st_d;
   logic [PW-1:0]   pix_q, pix_d;
   logic [LW-1:0]   line_q, line_d;
   logic [7:0]      frame_q, frame_d;
   logic [BW-1:0]   blk_q, blk_d;
   logic            sync_q, sync_d, f_sync_q, f_sync_d;
   logic            end_line_q, end_line_d, end_frame_q, end_frame_d, busy_q, busy_d;

   always_comb begin
      st_d    = st_q;
      pix_d   = pix_q;
      line_d  = line_q;
      frame_d = frame_q;
      blk_d   = blk_q;
      case (st_q)
         S_IDLE: if (run) begin
            st_d   = S_SYNC;
            line_d = '0;
         end
         S_SYNC: begin
            st_d  = S_ACTIVE;
            pix_d = '0;
         end
         S_ACTIVE: if (pix_q == PIX_LAST) begin
            pix_d = '0;
            blk_d = '0;
            if (line_q < LINE_LAST) begin
               st_d   = S_HBLANK;
               line_d = line_q + 1'b1;
            end else begin
               st_d    = S_VBLANK;
               line_d  = '0;
               frame_d = frame_q + 1'b1;
            end
         end else pix_d = pix_q + 1'b1;
         S_HBLANK: if (blk_q == HB_LAST) st_d = S_SYNC;
                   else blk_d = blk_q + 1'b1;
         // run is only looked at here and in IDLE, so a frame is never cut short
         S_VBLANK: if (blk_q == VB_LAST) st_d = run ? S_SYNC : S_IDLE;
                   else blk_d = blk_q + 1'b1;
         default: st_d = S_IDLE;
      endcase
      sync_d      = st_d == S_SYNC;
      f_sync_d    = sync_d && line_d == '0;
      end_line_d  = st_d == S_ACTIVE && pix_d == PIX_LAST;
      end_frame_d = (sync_d || st_d == S_ACTIVE) && line_d == LINE_LAST;
      busy_d      = st_d != S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= S_IDLE;
         pix_q       <= '0;
         line_q      <= '0;
         frame_q     <= '0;
         blk_q       <= '0;
         sync_q      <= 1'b0;
         f_sync_q    <= 1'b0;
         end_line_q  <= 1'b0;
         end_frame_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         pix_q       <= pix_d;
         line_q      <= line_d;
         frame_q     <= frame_d;
         blk_q       <= blk_d;
         sync_q      <= sync_d;
         f_sync_q    <= f_sync_d;
         end_line_q  <= end_line_d;
         end_frame_q <= end_frame_d;
         busy_q      <= busy_d;
      end
   end

   assign sync      = sync_q;
   assign f_sync    = f_sync_q;
   assign endLine   = end_line_q;
   assign endFrame  = end_frame_q;
   assign pix_cnt   = pix_q;
   assign line_cnt  = line_q;
   assign frame_cnt = frame_q;
   assign busy      = busy_q;
endmodule

// File: tb/tb_line_timing_gen.sv
// tb_line_timing_gen: directed checks of line_timing_gen with a 2-line frame instance (a)
// and a 1-line frame instance (b).
module tb_line_timing_gen;
   logic clk = 1'b0, rst_n = 1'b0, run_a = 1'b0, run_b = 1'b0;
   logic f_sync_a, sync_a, end_line_a, end_frame_a, busy_a;
   logic f_sync_b, sync_b, end_line_b, end_frame_b, busy_b;
   logic [11:0] pix_a, pix_b;
   logic [9:0]  line_a, line_b;
   logic [7:0]  frame_a, frame_b;
   int n_chk = 0, n_pass = 0;

   always #8 clk = ~clk;

   line_timing_gen #(.PIX_PER_LINE(4), .LINES_PER_FRAME(2), .HBLANK(2), .VBLANK(3), .PW(12), .LW(10)) dut_a (
      .clk(clk), .rst_n(rst_n), .run(run_a), .f_sync(f_sync_a), .sync(sync_a), .endLine(end_line_a),
      .endFrame(end_frame_a), .pix_cnt(pix_a), .line_cnt(line_a), .frame_cnt(frame_a), .busy(busy_a));

   line_timing_gen #(.PIX_PER_LINE(4), .LINES_PER_FRAME(1), .HBLANK(2), .VBLANK(3), .PW(12), .LW(10)) dut_b (
      .clk(clk), .rst_n(rst_n), .run(run_b), .f_sync(f_sync_b), .sync(sync_b), .endLine(end_line_b),
      .endFrame(end_frame_b), .pix_cnt(pix_b), .line_cnt(line_b), .frame_cnt(frame_b), .busy(busy_b));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      run_a = 1'b0;
      run_b = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
   endtask

   logic [31:0] m_sync, m_fsync, m_eline, m_eframe, m_busy;
   int pix_log[32], line_log[32], frame_log[32];
   int n_sync, n_fsync, n_ef, n_good;
   logic any_out;

   initial begin
      // reset and idle with run low
      repeat (2) tick();
      rst_n = 1'b1;
      any_out = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         any_out = any_out | sync_a | f_sync_a | end_line_a | end_frame_a | busy_a | (|pix_a) | (|line_a) | (|frame_a);
      end
      check("idle_outputs", {31'd0, any_out}, 32'd0);
      check("idle_busy", {31'd0, busy_a}, 32'd0);

      // continuous run: cycle k counted from the last IDLE cycle
      do_reset();
      run_a = 1'b1;
      m_sync = '0; m_fsync = '0; m_eline = '0; m_eframe = '0;
      for (int k = 1; k <= 31; k++) begin
         tick();
         m_sync[k] = sync_a;
         m_fsync[k] = f_sync_a;
         m_eline[k] = end_line_a;
         m_eframe[k] = end_frame_a;
         pix_log[k] = int'(pix_a);
         line_log[k] = int'(line_a);
         frame_log[k] = int'(frame_a);
      end
      check("run_sync", m_sync, (32'd1 << 1) | (32'd1 << 8) | (32'd1 << 16) | (32'd1 << 23) | (32'd1 << 31));
      check("run_fsync", m_fsync, (32'd1 << 1) | (32'd1 << 16) | (32'd1 << 31));
      check("run_endline", m_eline, (32'd1 << 5) | (32'd1 << 12) | (32'd1 << 20) | (32'd1 << 27));
      check("run_endframe_level", m_eframe, 32'h0000_1F00 | 32'h0F80_0000);
      check("run_ef_and_el", m_eframe & m_eline, (32'd1 << 12) | (32'd1 << 27));
      check("pix_at_4", pix_log[4], 2);
      check("pix_in_hblank", pix_log[6], 0);
      check("line_in_hblank", line_log[6], 1);
      check("line_in_vblank", line_log[13], 0);
      check("frame_before_vb", frame_log[12], 0);
      check("frame_after_vb", frame_log[13], 1);
      check("frame_second", frame_log[28], 2);

      // single-cycle run pulse gives exactly one frame
      do_reset();
      run_a = 1'b1;
      tick();
      run_a = 1'b0;
      n_sync = int'(sync_a); n_fsync = int'(f_sync_a); m_busy = '0;
      m_busy[1] = busy_a;
      for (int k = 2; k <= 30; k++) begin
         tick();
         n_sync += int'(sync_a);
         n_fsync += int'(f_sync_a);
         m_busy[k] = busy_a;
      end
      check("pulse_syncs", n_sync, 2);
      check("pulse_fsyncs", n_fsync, 1);
      check("pulse_busy_window", m_busy, 32'h0000_FFFE);
      check("pulse_frame_cnt", frame_a, 1);

      // run dropped during line 0
      do_reset();
      run_a = 1'b1;
      repeat (3) tick();
      run_a = 1'b0;
      n_sync = 0; n_fsync = 0; n_ef = 0;
      for (int k = 4; k <= 40; k++) begin
         tick();
         n_sync += int'(sync_a);
         n_fsync += int'(f_sync_a);
         n_ef += int'(end_frame_a & end_line_a);
      end
      check("drop_syncs", n_sync, 1);
      check("drop_fsyncs", n_fsync, 0);
      check("drop_frame_end", n_ef, 1);
      check("drop_busy", busy_a, 0);
      check("drop_frame_cnt", frame_a, 1);

      // reset asserted mid-line
      do_reset();
      run_a = 1'b1;
      repeat (11) tick();
      check("pre_rst_pix", pix_a, 2);
      check("pre_rst_line", line_a, 1);
      rst_n = 1'b0;
      #1;
      check("rst_strobes", {27'd0, sync_a, f_sync_a, end_line_a, end_frame_a, busy_a}, 32'd0);
      check("rst_counters", {2'd0, pix_a, line_a, frame_a}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("restart_sync", {30'd0, sync_a, f_sync_a}, 32'd3);
      check("restart_frame_cnt", frame_a, 0);

      // single-line frames with frame counter wrap
      do_reset();
      run_b = 1'b1;
      n_sync = 0; n_good = 0; n_ef = 0;
      for (int c = 1; c <= 2078; c++) begin
         tick();
         n_sync += int'(sync_b);
         n_good += int'(sync_b & f_sync_b & end_frame_b);
         n_ef += int'(end_frame_b & end_line_b);
         if (c == 2045) check("wrap_255", frame_b, 255);
         if (c == 2046) check("wrap_0", frame_b, 0);
      end
      check("l1_syncs", n_sync, 260);
      check("l1_sync_all_fsync", n_good, 260);
      check("l1_frame_ends", n_ef, 260);
      check("l1_frame_cnt_260", frame_b, 4);
      check("l1_line_cnt", line_b, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
